// File: rtl/frame_writer_if.sv
// -----------------------------------------------------------------------------
// frame_writer_if
// Bundles the signals between frame_writer and its surroundings: the vga
// counters, the draw/erase requests, and the sram request/response signals.
//   master : frame_writer side (drives address, data_write, read, write,
//            pending, erasing; receives everything else)
//   slave  : environment side (vga, camera tracker, sram and its mux)
// -----------------------------------------------------------------------------
interface frame_writer_if;
  logic [10:0] hcounter;
  logic [9:0]  vcounter;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  colour;
  logic        draw;
  logic        erase;
  logic        ready;
  logic [15:0] data_read;
  logic [17:0] address;
  logic [15:0] data_write;
  logic        read;
  logic        write;
  logic        pending;
  logic        erasing;

  modport master (
    input  hcounter, vcounter, x, y, colour, draw, erase, ready, data_read,
    output address, data_write, read, write, pending, erasing
  );

  modport slave (
    output hcounter, vcounter, x, y, colour, draw, erase, ready, data_read,
    input  address, data_write, read, write, pending, erasing
  );
endinterface

// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
// Write-side SRAM requester for the 640x480 8-bpp framebuffer. Outside the
// active display area it commits the latest draw point with a read-modify-write
// of the 16-bit word holding that pixel, and clears the whole buffer on an
// erase request, resuming the clear in later blanking windows as needed.
// Ports:
//   clk   : pixel clock
//   reset : asynchronous, active-high
//   bus   : frame_writer_if.master (vga counters, draw/erase inputs, sram
//           address/data_write/read/write requests, ready/data_read response,
//           pending/erasing status)
// -----------------------------------------------------------------------------
module frame_writer #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int WIN_LAST = 523,
  parameter int WORDS    = H_PIXELS * V_PIXELS / 2
) (
  input  logic           clk,
  input  logic           reset,
  frame_writer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ER_REQ, ER_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  colour_q, colour_d;
  logic        pending_q, pending_d;
  logic        erasing_q, erasing_d;
  logic [17:0] ptr_q, ptr_d;
  logic [17:0] address_q, address_d;
  logic [15:0] data_write_q, data_write_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        erase_prev_q, erase_prev_d;
  logic        ready_prev_q, ready_prev_d;

  logic        win;
  logic        ready_rise;
  logic        erase_rise;
  logic        in_range;
  logic        launch;
  logic [17:0] word_addr;

  assign win        = (bus.vcounter >= 10'(V_PIXELS)) && (bus.vcounter <= 10'(WIN_LAST));
  assign ready_rise = bus.ready && !ready_prev_q;
  assign erase_rise = bus.erase && !erase_prev_q;
  assign in_range   = (bus.x < 10'(H_PIXELS)) && (bus.y < 10'(V_PIXELS));
  // Two pixels per word: x[0] picks the byte, x[9:1] the word within the line.
  assign word_addr  = 18'(y_q) * 18'(H_PIXELS / 2) + 18'(x_q[9:1]);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    pending_d    = pending_q;
    erasing_d    = erasing_q;
    ptr_d        = ptr_q;
    address_d    = address_q;
    data_write_d = data_write_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    erase_prev_d = bus.erase;
    ready_prev_d = bus.ready;
    launch       = 1'b0;

    // Requests are registered: read/write are raised on entry to the *_REQ
    // state, so each is high for exactly the one cycle spent there.
    unique case (state_q)
      IDLE: begin
        if (win && bus.ready && erasing_q) begin
          state_d      = ER_REQ;
          write_d      = 1'b1;
          address_d    = ptr_q;
          data_write_d = '0;
        end else if (win && bus.ready && pending_q) begin
          state_d   = RD_REQ;
          read_d    = 1'b1;
          address_d = word_addr;
          launch    = 1'b1;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (ready_rise) begin
          data_write_d = x_q[0] ? {colour_q, bus.data_read[7:0]}
                                : {bus.data_read[15:8], colour_q};
          write_d      = 1'b1;
          state_d      = WR_REQ;
        end
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (ready_rise) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end
      end
      ER_REQ:  state_d = ER_WAIT;
      ER_WAIT: begin
        if (ready_rise) begin
          if (ptr_q == 18'(WORDS - 1)) begin
            erasing_d = 1'b0;
            ptr_d     = '0;
          end else begin
            ptr_d = ptr_q + 18'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The latch is only open while idle; once a read-modify-write launches it
    // is frozen so the merge uses the same point that was addressed.
    if (bus.draw && in_range && !erasing_q && (state_q == IDLE) && !launch) begin
      x_d       = bus.x;
      y_d       = bus.y;
      colour_d  = bus.colour;
      pending_d = 1'b1;
    end

    // Erase wins over any held draw; a running read-modify-write still
    // finishes because the FSM does not look at pending after launch.
    if (erase_rise && !erasing_q) begin
      erasing_d = 1'b1;
      ptr_d     = '0;
      pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      pending_q    <= 1'b0;
      erasing_q    <= 1'b0;
      ptr_q        <= '0;
      address_q    <= '0;
      data_write_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      erase_prev_q <= 1'b0;
      ready_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      pending_q    <= pending_d;
      erasing_q    <= erasing_d;
      ptr_q        <= ptr_d;
      address_q    <= address_d;
      data_write_q <= data_write_d;
      read_q       <= read_d;
      write_q      <= write_d;
      erase_prev_q <= erase_prev_d;
      ready_prev_q <= ready_prev_d;
    end
  end

  assign bus.address    = address_q;
  assign bus.data_write = data_write_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.pending    = pending_q;
  assign bus.erasing    = erasing_q;

endmodule
